rvv_backend_mul_rs: RTL and testbench

RVV_BACKEND_MUL_RS -- requirements
Module: rvv_backend_mul_rs

---
 rtl/rvv_backend_mul_rs_pkg.sv | 8 +
 rtl/rvv_backend.svh | 10 +
 rtl/rvv_backend_mul_rs_mem.sv | 21 ++
 rtl/rvv_backend_mul_rs.sv | 80 ++++++++
 tb/tb_rvv_backend_mul_rs.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rvv_backend_mul_rs_pkg.sv
// rvv_backend_mul_rs_pkg: constants and grant helper for the multiply reservation station
package rvv_backend_mul_rs_pkg;
  localparam int MUL_RS_DEPTH = 8;
  // Port 1 is granted only alongside port 0, so grants stay contiguous and port 0 is the older slot.
  function automatic logic [1:0] grant2(input logic [1:0] req, input logic ok0, input logic ok1);
    return {req[1] & req[0] & ok0 & ok1, req[0] & ok0};
  endfunction
endpackage

// File: rtl/rvv_backend.svh
// rvv_backend.svh: shared backend definitions for the multiply issue path
// Provides `NUM_MUL (multiply lanes) and MUL_RS_t (reservation station entry).
`ifndef RVV_BACKEND_SVH
`define RVV_BACKEND_SVH
`define NUM_MUL 2
typedef struct packed {
  logic [7:0]  uop_id;
  logic [31:0] vs1_data;
} MUL_RS_t;
`endif

// File: rtl/rvv_backend_mul_rs_mem.sv
// rvv_backend_mul_rs_mem: DEPTH x MUL_RS_t storage, `NUM_MUL write ports, `NUM_MUL combinational read ports
// Ports: clk; we/waddr/wdata per write port; raddr/rdata per read port. Contents are never reset.
`include "rvv_backend.svh"
module rvv_backend_mul_rs_mem #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic [`NUM_MUL-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0]   waddr [`NUM_MUL],
  input  MUL_RS_t                    wdata [`NUM_MUL],
  input  logic [$clog2(DEPTH)-1:0]   raddr [`NUM_MUL],
  output MUL_RS_t                    rdata [`NUM_MUL]
);
  MUL_RS_t mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < `NUM_MUL; i++)
      if (we[i]) mem[waddr[i]] <= wdata[i];
  for (genvar g = 0; g < `NUM_MUL; g++) begin : g_rd
    assign rdata[g] = mem[raddr[g]];
  end
endmodule

// File: rtl/rvv_backend_mul_rs.sv
// rvv_backend_mul_rs: multiply reservation station, a 2-push/2-pop FIFO of MUL_RS_t entries
// Ports: clk, rst_n (sync active-low), trap_flush_rvv; dp2rs_push/dp2rs_data in, rs2dp_full/rs2dp_1left_to_full out;
// rs2ex_uop_data ([0]=oldest), rs2ex_fifo_empty, rs2ex_fifo_1left_to_empty out; ex2rs_fifo_pop in.
// Macro RVV_MUL_RS_ERR_CHK_EN adds the sticky protocol error output rs_err.
`include "rvv_backend.svh"
module rvv_backend_mul_rs
  import rvv_backend_mul_rs_pkg::*;
#(
  parameter int DEPTH = MUL_RS_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trap_flush_rvv,
  input  logic [`NUM_MUL-1:0] dp2rs_push,
  input  MUL_RS_t             dp2rs_data [`NUM_MUL],
  output logic                rs2dp_full,
  output logic                rs2dp_1left_to_full,
  output MUL_RS_t             rs2ex_uop_data [`NUM_MUL],
  output logic                rs2ex_fifo_empty,
  output logic                rs2ex_fifo_1left_to_empty,
  input  logic [`NUM_MUL-1:0] ex2rs_fifo_pop
`ifdef RVV_MUL_RS_ERR_CHK_EN
  ,
  output logic                rs_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_1FULL = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] ONE = AW'(1);
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, n_push, n_pop;
  logic [1:0] push_acc, pop_acc;
  logic live;
  logic [AW-1:0] waddr [`NUM_MUL];
  logic [AW-1:0] raddr [`NUM_MUL];
  assign rs2dp_full = count == C_FULL;
  assign rs2dp_1left_to_full = count == C_1FULL;
  assign rs2ex_fifo_empty = count == '0;
  assign rs2ex_fifo_1left_to_empty = count == (AW+1)'(1);
  // Grants look only at the registered count; slots freed by this cycle's pops are not reused until next cycle.
  assign push_acc = grant2(dp2rs_push, !rs2dp_full, count < C_1FULL);
  assign pop_acc = grant2(ex2rs_fifo_pop, !rs2ex_fifo_empty, count >= (AW+1)'(2));
  assign n_push = (AW+1)'(push_acc[0]) + (AW+1)'(push_acc[1]);
  assign n_pop = (AW+1)'(pop_acc[0]) + (AW+1)'(pop_acc[1]);
  assign live = rst_n & !trap_flush_rvv;
  assign waddr[0] = wptr;
  assign waddr[1] = wptr + ONE;
  assign raddr[0] = rptr;
  assign raddr[1] = rptr + ONE;
  rvv_backend_mul_rs_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_acc & {2{live}}),
    .waddr (waddr),
    .wdata (dp2rs_data),
    .raddr (raddr),
    .rdata (rs2ex_uop_data)
  );
  always_ff @(posedge clk) begin
    if (!live) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + n_push[AW-1:0];
      rptr <= rptr + n_pop[AW-1:0];
      count <= count + n_push - n_pop;
    end
  end
`ifdef RVV_MUL_RS_ERR_CHK_EN
  logic err_now;
  assign err_now = (|dp2rs_push & rs2dp_full) | (dp2rs_push[1] & !dp2rs_push[0])
                 | (|ex2rs_fifo_pop & rs2ex_fifo_empty)
                 | (ex2rs_fifo_pop[1] & (!ex2rs_fifo_pop[0] | count < (AW+1)'(2)));
  always_ff @(posedge clk) begin
    if (!rst_n) rs_err <= 1'b0;
    else if (err_now) rs_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_rvv_backend_mul_rs.sv
// tb_rvv_backend_mul_rs: queue-model bench for the multiply reservation station (DEPTH=8)
`include "rvv_backend.svh"
module tb_rvv_backend_mul_rs;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trap_flush_rvv = 1'b0;
  logic [`NUM_MUL-1:0] dp2rs_push = '0;
  logic [`NUM_MUL-1:0] ex2rs_fifo_pop = '0;
  MUL_RS_t dp2rs_data [`NUM_MUL];
  MUL_RS_t rs2ex_uop_data [`NUM_MUL];
  logic rs2dp_full, rs2dp_1left_to_full, rs2ex_fifo_empty, rs2ex_fifo_1left_to_empty;
`ifdef RVV_MUL_RS_ERR_CHK_EN
  logic rs_err;
`endif
  MUL_RS_t q[$];
  bit exp_err;
  bit chk;
  int n_tests, n_fail, seq;
  always #5 clk = ~clk;
  rvv_backend_mul_rs #(.DEPTH(DEPTH)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .trap_flush_rvv            (trap_flush_rvv),
    .dp2rs_push                (dp2rs_push),
    .dp2rs_data                (dp2rs_data),
    .rs2dp_full                (rs2dp_full),
    .rs2dp_1left_to_full       (rs2dp_1left_to_full),
    .rs2ex_uop_data            (rs2ex_uop_data),
    .rs2ex_fifo_empty          (rs2ex_fifo_empty),
    .rs2ex_fifo_1left_to_empty (rs2ex_fifo_1left_to_empty),
    .ex2rs_fifo_pop            (ex2rs_fifo_pop)
`ifdef RVV_MUL_RS_ERR_CHK_EN
    ,
    .rs_err                    (rs_err)
`endif
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  function automatic MUL_RS_t mk(input int n);
    return {8'(n), 32'hC0DE_0000 + 32'(n)};
  endfunction
  task automatic step(input logic [1:0] push, input logic [1:0] pop, input bit flush, input bit rst_v,
                      input MUL_RS_t d0, input MUL_RS_t d1);
    int n;
    bit p0, p1, o0, o1;
    dp2rs_push = push;
    ex2rs_fifo_pop = pop;
    trap_flush_rvv = flush;
    rst_n = rst_v;
    dp2rs_data[0] = d0;
    dp2rs_data[1] = d1;
    @(posedge clk);
    n = q.size();
    p0 = push[0] && n < DEPTH;
    p1 = push[1] && p0 && n <= DEPTH - 2;
    o0 = pop[0] && n > 0;
    o1 = pop[1] && o0 && n >= 2;
    if ((push != 0 && n == DEPTH) || (push[1] && !push[0]) || (pop != 0 && n == 0)
        || (pop[1] && !pop[0]) || (pop[1] && n < 2)) exp_err = 1;
    if (!rst_v) begin
      q.delete();
      exp_err = 0;
    end else if (flush) q.delete();
    else begin
      if (o0) void'(q.pop_front());
      if (o1) void'(q.pop_front());
      if (p0) q.push_back(d0);
      if (p1) q.push_back(d1);
    end
    #1;
  endtask
  task automatic st(input logic [1:0] push, input logic [1:0] pop, input bit flush);
    step(push, pop, flush, 1'b1, mk(seq), mk(seq + 1));
    seq += 2;
  endtask
  always @(negedge clk) begin
    if (chk) begin
      check("empty", 64'(rs2ex_fifo_empty), 64'(q.size() == 0));
      check("1left_to_empty", 64'(rs2ex_fifo_1left_to_empty), 64'(q.size() == 1));
      check("full", 64'(rs2dp_full), 64'(q.size() == DEPTH));
      check("1left_to_full", 64'(rs2dp_1left_to_full), 64'(q.size() == DEPTH - 1));
      if (q.size() >= 1) check("data0", 64'(rs2ex_uop_data[0]), 64'(q[0]));
      if (q.size() >= 2) check("data1", 64'(rs2ex_uop_data[1]), 64'(q[1]));
`ifdef RVV_MUL_RS_ERR_CHK_EN
      check("rs_err", 64'(rs_err), 64'(exp_err));
`endif
    end
  end
  initial begin
    MUL_RS_t a, b;
    logic [1:0] pat [3];
    a = {8'h11, 32'hDEAD_0001};
    b = {8'h22, 32'hBEEF_0002};
    pat[0] = 2'b00;
    pat[1] = 2'b01;
    pat[2] = 2'b11;
    seq = 100;
    step(2'b00, 2'b00, 1'b0, 1'b0, mk(0), mk(1));
    step(2'b00, 2'b00, 1'b0, 1'b0, mk(0), mk(1));
    chk = 1;
    check("rst_empty", 64'(rs2ex_fifo_empty), 64'd1);
    check("rst_1left_to_empty", 64'(rs2ex_fifo_1left_to_empty), 64'd0);
    check("rst_full", 64'(rs2dp_full), 64'd0);
    check("rst_1left_to_full", 64'(rs2dp_1left_to_full), 64'd0);
    step(2'b01, 2'b00, 1'b0, 1'b1, a, mk(2));
    check("a_empty", 64'(rs2ex_fifo_empty), 64'd0);
    check("a_1left_to_empty", 64'(rs2ex_fifo_1left_to_empty), 64'd1);
    check("a_data0", 64'(rs2ex_uop_data[0]), 64'(a));
    st(2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) st(2'b11, 2'b00, 1'b0);
    check("fill_full", 64'(rs2dp_full), 64'd1);
    check("fill_size", 64'(q.size()), 64'd8);
    st(2'b01, 2'b00, 1'b0);
    check("drop_full", 64'(rs2dp_full), 64'd1);
    check("drop_size", 64'(q.size()), 64'd8);
`ifdef RVV_MUL_RS_ERR_CHK_EN
    check("err_push_full", 64'(rs_err), 64'd1);
`endif
    st(2'b00, 2'b01, 1'b0);
    check("c7_1left_to_full", 64'(rs2dp_1left_to_full), 64'd1);
    st(2'b11, 2'b00, 1'b0);
    check("c7_push2_full", 64'(rs2dp_full), 64'd1);
    check("c7_push2_size", 64'(q.size()), 64'd8);
    st(2'b11, 2'b11, 1'b0);
    check("pp_full_size", 64'(q.size()), 64'd6);
    check("pp_full_flag", 64'(rs2dp_full), 64'd0);
    st(2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 60; i++) st(pat[$urandom_range(0, 2)], pat[$urandom_range(0, 2)], 1'b0);
    for (int i = 0; i < 8 && q.size() > 0; i++) st(2'b00, 2'b11, 1'b0);
    check("drain_empty", 64'(rs2ex_fifo_empty), 64'd1);
    st(2'b00, 2'b00, 1'b1);
    st(2'b11, 2'b00, 1'b0);
    st(2'b11, 2'b00, 1'b0);
    st(2'b01, 2'b00, 1'b0);
    check("c5_size", 64'(q.size()), 64'd5);
    st(2'b11, 2'b11, 1'b1);
    check("flush_size", 64'(q.size()), 64'd0);
    check("flush_empty", 64'(rs2ex_fifo_empty), 64'd1);
    step(2'b01, 2'b00, 1'b0, 1'b1, b, mk(3));
    check("b_data0", 64'(rs2ex_uop_data[0]), 64'(b));
    st(2'b11, 2'b00, 1'b0);
    check("c3_size", 64'(q.size()), 64'd3);
    st(2'b00, 2'b10, 1'b0);
    check("pop1_only_size", 64'(q.size()), 64'd3);
    check("pop1_only_data0", 64'(rs2ex_uop_data[0]), 64'(b));
`ifdef RVV_MUL_RS_ERR_CHK_EN
    check("err_pop1_only", 64'(rs_err), 64'd1);
`endif
    st(2'b00, 2'b00, 1'b1);
`ifdef RVV_MUL_RS_ERR_CHK_EN
    check("err_after_flush", 64'(rs_err), 64'd1);
`endif
    step(2'b00, 2'b00, 1'b0, 1'b0, mk(0), mk(1));
    check("rst2_empty", 64'(rs2ex_fifo_empty), 64'd1);
`ifdef RVV_MUL_RS_ERR_CHK_EN
    check("err_after_reset", 64'(rs_err), 64'd0);
`endif
    step(2'b00, 2'b00, 1'b0, 1'b1, mk(0), mk(1));
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
